// File: rtl/fetch_buffer_ctrl.sv
// fetch_buffer_ctrl
// Occupancy tracker and strobe generator for the fetch-group buffer that sits
// between the fetch stage and decode. The FIFO storage lives elsewhere. This
// block decides when groups enter or leave it, when it is cleared, and when
// fetch must be held off.
//
// Parameters
//   DEPTH_LOG   log2 of buffer depth in fetch groups (DEPTH = 2**DEPTH_LOG)
//   SKID        groups kept free for fetches already in flight when stall rises
//               (1 <= SKID < DEPTH)
//
// Ports
//   clock        single clock, rising edge
//   reset        asynchronous active-low reset
//   fetch_valid  fetch presents one group this cycle
//   dec_ready    decode accepts one group this cycle
//   flush        redirect, discards all buffered groups
//   buf_enq      enqueue strobe to buffer FIFOs
//   buf_deq      dequeue strobe to buffer FIFOs
//   buf_clear    synchronous clear to buffer FIFOs
//   dec_valid    a buffered group is available to decode
//   fetch_stall  back-pressure to fetch
//   occupancy    current group count (0..DEPTH)
//   overflow     sticky: a group arrived with no free slot and was dropped
//
// Optional build macro FB_PERF_CNT_EN adds:
//   stall_cycles  32-bit wrapping count of cycles with fetch_stall high outside reset
//   flush_count   16-bit wrapping count of FLUSH entries
//
// state  | meaning
// -------+-------------------------------------------------------------
// EMPTY  | no groups buffered
// ACTIVE | 1..DEPTH-1 groups buffered
// FULL   | DEPTH groups buffered; further fetches are dropped
// FLUSH  | buffer being cleared after a redirect; no strobes

module fetch_buffer_ctrl #(
   parameter int DEPTH_LOG = 3,
   parameter int SKID      = 1
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 fetch_valid,
   input  logic                 dec_ready,
   input  logic                 flush,
   output logic                 buf_enq,
   output logic                 buf_deq,
   output logic                 buf_clear,
   output logic                 dec_valid,
   output logic                 fetch_stall,
   output logic [DEPTH_LOG:0]   occupancy,
   output logic                 overflow
`ifdef FB_PERF_CNT_EN
   ,
   output logic [31:0]          stall_cycles,
   output logic [15:0]          flush_count
`endif
);

   localparam int DEPTH_I    = 1 << DEPTH_LOG;
   localparam int STALL_TH_I = DEPTH_I - SKID;

   localparam logic [DEPTH_LOG:0] DEPTH_V  = DEPTH_I[DEPTH_LOG:0];
   localparam logic [DEPTH_LOG:0] STALL_TH = STALL_TH_I[DEPTH_LOG:0];
   localparam logic [DEPTH_LOG:0] ONE      = 1;

   typedef enum logic [1:0] {
      ST_EMPTY  = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_FULL   = 2'd2,
      ST_FLUSH  = 2'd3
   } state_t;

   state_t             state, state_nxt;
   logic [DEPTH_LOG:0] occ_nxt;
   logic               overflow_nxt;
   logic               in_flush;
   logic               overflow_set;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= ST_EMPTY;
         occupancy <= '0;
         overflow  <= 1'b0;
      end else begin
         state     <= state_nxt;
         occupancy <= occ_nxt;
         overflow  <= overflow_nxt;
      end
   end

   // Strobes are gated with reset so the FIFOs see clear/stall and no
   // enq/deq for the whole time reset is low, with no clock edge needed.
   always_comb begin
      in_flush     = (state == ST_FLUSH);
      buf_enq      = reset & fetch_valid & (occupancy < DEPTH_V) & ~in_flush & ~flush;
      dec_valid    = reset & (occupancy != '0) & ~in_flush;
      buf_deq      = dec_valid & dec_ready & ~flush;
      buf_clear    = in_flush | ~reset;
      fetch_stall  = (occupancy >= STALL_TH) | in_flush | flush | ~reset;
      overflow_set = fetch_valid & (occupancy == DEPTH_V) & ~in_flush;

      occ_nxt      = occupancy;
      state_nxt    = state;
      overflow_nxt = overflow | overflow_set;

      if (flush) begin
         occ_nxt      = '0;
         state_nxt    = ST_FLUSH;
         overflow_nxt = 1'b0;
      end else begin
         case ({buf_enq, buf_deq})
            2'b10:   occ_nxt = occupancy + ONE;
            2'b01:   occ_nxt = occupancy - ONE;
            default: occ_nxt = occupancy;
         endcase
         // Leaving FLUSH: occupancy is already zero, so this lands in EMPTY.
         if (occ_nxt == '0)
            state_nxt = ST_EMPTY;
         else if (occ_nxt == DEPTH_V)
            state_nxt = ST_FULL;
         else
            state_nxt = ST_ACTIVE;
      end
   end

`ifdef FB_PERF_CNT_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         if (fetch_stall)
            stall_cycles <= stall_cycles + 32'd1;
         // A held flush is one redirect; count only the entry into FLUSH.
         if (flush && !in_flush)
            flush_count <= flush_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_buffer_ctrl.sv
module tb_fetch_buffer_ctrl;

   logic       clock = 1'b0;
   logic       reset;
   logic       fetch_valid, dec_ready, flush;
   logic       buf_enq, buf_deq, buf_clear, dec_valid, fetch_stall;
   logic [3:0] occupancy;
   logic       overflow;
`ifdef FB_PERF_CNT_EN
   logic [31:0] stall_cycles;
   logic [15:0] flush_count;
   logic [15:0] fc_before;
`endif

   int checks   = 0;
   int failures = 0;

   fetch_buffer_ctrl #(.DEPTH_LOG(3), .SKID(1)) dut (
      .clock       (clock),
      .reset       (reset),
      .fetch_valid (fetch_valid),
      .dec_ready   (dec_ready),
      .flush       (flush),
      .buf_enq     (buf_enq),
      .buf_deq     (buf_deq),
      .buf_clear   (buf_clear),
      .dec_valid   (dec_valid),
      .fetch_stall (fetch_stall),
      .occupancy   (occupancy),
      .overflow    (overflow)
`ifdef FB_PERF_CNT_EN
      ,
      .stall_cycles(stall_cycles),
      .flush_count (flush_count)
`endif
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b0; fetch_valid = 1'b0; dec_ready = 1'b0; flush = 1'b0;
      #3;
      check("rst_enq",   buf_enq,     1'b0);
      check("rst_deq",   buf_deq,     1'b0);
      check("rst_clear", buf_clear,   1'b1);
      check("rst_dvalid",dec_valid,   1'b0);
      check("rst_stall", fetch_stall, 1'b1);
      check("rst_occ",   occupancy,   4'd0);
      check("rst_ovf",   overflow,    1'b0);
`ifdef FB_PERF_CNT_EN
      check("rst_stallcnt", stall_cycles, 32'd0);
      check("rst_flushcnt", flush_count,  16'd0);
`endif
      tick();
      reset = 1'b1;
      #1;
      check("post_rst_stall", fetch_stall, 1'b0);
      check("post_rst_clear", buf_clear,   1'b0);
      check("post_rst_dvalid",dec_valid,   1'b0);

      // Fill: 10 cycles of fetch with decode blocked. Stall rises at occupancy 7,
      // occupancy saturates at 8, the 9th group is dropped and sets overflow.
      fetch_valid = 1'b1; dec_ready = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         #1;
         check("fill_enq",   buf_enq,     (i <= 8) ? 1'b1 : 1'b0);
         check("fill_stall", fetch_stall, (i >= 8) ? 1'b1 : 1'b0);
         tick();
         check("fill_occ", occupancy, (i <= 8) ? i : 8);
         check("fill_ovf", overflow,  (i >= 9) ? 1'b1 : 1'b0);
      end
      check("full_dvalid", dec_valid, 1'b1);

      // Full with dequeue: no bypass, enqueue refused.
      dec_ready = 1'b1;
      #1;
      check("fulldq_enq", buf_enq, 1'b0);
      check("fulldq_deq", buf_deq, 1'b1);
      tick();
      check("fulldq_occ", occupancy, 4'd7);
      check("fulldq_ovf", overflow,  1'b1);

      // Flush at occupancy 7 clears the sticky overflow.
      flush = 1'b1;
      #1;
      check("fl7_enq",   buf_enq,     1'b0);
      check("fl7_deq",   buf_deq,     1'b0);
      check("fl7_stall", fetch_stall, 1'b1);
      tick();
      flush = 1'b0; fetch_valid = 1'b0; dec_ready = 1'b0;
      #1;
      check("fl7_clear", buf_clear, 1'b1);
      check("fl7_occ",   occupancy, 4'd0);
      check("fl7_ovf",   overflow,  1'b0);
      check("fl7_enq_in_flush", buf_enq, 1'b0);
      tick();
      check("fl7_clear_off", buf_clear,   1'b0);
      check("fl7_stall_off", fetch_stall, 1'b0);

      // Streaming at occupancy 4.
      fetch_valid = 1'b1;
      repeat (4) tick();
      check("stream_pre_occ", occupancy, 4'd4);
      dec_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         #1;
         check("stream_enq", buf_enq, 1'b1);
         check("stream_deq", buf_deq, 1'b1);
         tick();
         check("stream_occ", occupancy, 4'd4);
      end

      // Flush pulse at occupancy 5 with fetch and decode both active.
      dec_ready = 1'b0;
      tick();
      check("flush5_pre_occ", occupancy, 4'd5);
      dec_ready = 1'b1; flush = 1'b1;
      #1;
      check("flush5_enq",   buf_enq,     1'b0);
      check("flush5_deq",   buf_deq,     1'b0);
      check("flush5_stall", fetch_stall, 1'b1);
      tick();
      flush = 1'b0; fetch_valid = 1'b0; dec_ready = 1'b0;
      #1;
      check("flush5_clear",  buf_clear, 1'b1);
      check("flush5_occ",    occupancy, 4'd0);
      check("flush5_ovf",    overflow,  1'b0);
      check("flush5_dvalid", dec_valid, 1'b0);
      tick();
      check("flush5_empty_clear", buf_clear,   1'b0);
      check("flush5_empty_stall", fetch_stall, 1'b0);

      // Back-to-back flush held for 3 cycles at occupancy 2.
      fetch_valid = 1'b1;
      repeat (2) tick();
      check("b2b_pre_occ", occupancy, 4'd2);
      fetch_valid = 1'b0;
`ifdef FB_PERF_CNT_EN
      fc_before = flush_count;
`endif
      flush = 1'b1;
      tick();
      check("b2b_clear1", buf_clear, 1'b1);
      tick();
      check("b2b_clear2", buf_clear, 1'b1);
      tick();
      flush = 1'b0;
      #1;
      check("b2b_clear3", buf_clear, 1'b1);
      check("b2b_occ",    occupancy, 4'd0);
      tick();
      check("b2b_empty_clear", buf_clear,   1'b0);
      check("b2b_empty_stall", fetch_stall, 1'b0);
`ifdef FB_PERF_CNT_EN
      check("b2b_flushcnt", flush_count, fc_before + 16'd1);
`endif

      // Asynchronous reset mid-stream at occupancy 6.
      fetch_valid = 1'b1;
      repeat (6) tick();
      check("mid_pre_occ", occupancy, 4'd6);
      #2;
      reset = 1'b0;
      #1;
      check("mid_rst_occ",    occupancy,   4'd0);
      check("mid_rst_enq",    buf_enq,     1'b0);
      check("mid_rst_deq",    buf_deq,     1'b0);
      check("mid_rst_clear",  buf_clear,   1'b1);
      check("mid_rst_dvalid", dec_valid,   1'b0);
      check("mid_rst_stall",  fetch_stall, 1'b1);
      fetch_valid = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      check("mid_post_occ",    occupancy,   4'd0);
      check("mid_post_dvalid", dec_valid,   1'b0);
      check("mid_post_stall",  fetch_stall, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
